// File: rtl/i2s_pkg.sv
// ---------------------------------------------------------------------------
// i2s_pkg
// Shared definitions for the I2S transmit serializer slice.
//   FRAME_SLOTS / SLOT_BITS : frame geometry (64 bit-clock slots, 32 per channel)
//   SLOT_W                  : width of the slot counter
//   stereo_pair_t           : left/right sample pair, samples right-aligned in
//                             SLOT_BITS-wide fields (upper bits zero)
//   slot_bit()              : serial bit for a channel position (I2S one-bit delay)
// ---------------------------------------------------------------------------
package i2s_pkg;

  localparam int FRAME_SLOTS = 64;
  localparam int SLOT_BITS   = 32;
  localparam int SLOT_W      = 6;

  localparam logic [SLOT_W-1:0] LAST_SLOT = 6'd63;

  typedef struct packed {
    logic [SLOT_BITS-1:0] left;
    logic [SLOT_BITS-1:0] right;
  } stereo_pair_t;

  // Position 0 is the I2S delay bit; positions 1..width carry MSB..LSB;
  // everything past the sample is padded with zero.
  function automatic logic slot_bit(input logic [SLOT_BITS-1:0] sample,
                                    input logic [4:0]           pos,
                                    input logic [5:0]           width);
    logic [5:0] idx;
    logic       bit_v;
    idx = width - {1'b0, pos};
    if ((pos != 5'd0) && ({1'b0, pos} <= width)) begin
      bit_v = sample[idx[4:0]];
    end else begin
      bit_v = 1'b0;
    end
    return bit_v;
  endfunction

endpackage

// File: rtl/i2s_tx_serializer_if.sv
// ---------------------------------------------------------------------------
// i2s_tx_serializer_if
// Sample-pair handshake between the S/PDIF decoder and the I2S serializer.
//   in_valid  : sample pair offered (source -> serializer)
//   in_ready  : holding buffer empty (serializer -> source)
//   in_left   : left sample, two's complement, WIDTH bits
//   in_right  : right sample, two's complement, WIDTH bits
// Modports: master = sample source, slave = serializer.
// ---------------------------------------------------------------------------
interface i2s_tx_serializer_if #(
  parameter int WIDTH = 24
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_left;
  logic [WIDTH-1:0] in_right;

  modport master (output in_valid, output in_left, output in_right, input in_ready);
  modport slave  (input in_valid, input in_left, input in_right, output in_ready);

endinterface

// File: rtl/i2s_slot_counter.sv
// ---------------------------------------------------------------------------
// i2s_slot_counter
// Strobe-driven 64-slot frame counter. Resets to slot 63 so the first strobe
// after reset starts a frame.
//   clk_in      in  system clock
//   rst_n       in  asynchronous active-low reset
//   bit_strobe  in  one-cycle pulse per bit-clock period
//   lrclk       out word select (slot bit 5), registered
//   pos_next    out channel position of the slot being entered
//   chan_next   out channel of the slot being entered (0 = left)
//   frame_load  out high on the strobe that wraps slot 63 -> 0
// ---------------------------------------------------------------------------
module i2s_slot_counter
  import i2s_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       bit_strobe,
  output logic       lrclk,
  output logic [4:0] pos_next,
  output logic       chan_next,
  output logic       frame_load
);

  logic [SLOT_W-1:0] slot_q;
  logic [SLOT_W-1:0] slot_d;

  // Next slot: advance by one per strobe, natural 6-bit wrap 63 -> 0
  always_comb begin
    slot_d = slot_q;
    if (bit_strobe) begin
      slot_d = slot_q + 6'd1;
    end else begin
      slot_d = slot_q;
    end
  end

  // Slot register
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= LAST_SLOT;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign lrclk      = slot_q[5];
  assign pos_next   = slot_d[4:0];
  assign chan_next  = slot_d[5];
  assign frame_load = bit_strobe && (slot_q == LAST_SLOT);

endmodule

// File: rtl/i2s_tx_serializer.sv
// ---------------------------------------------------------------------------
// i2s_tx_serializer
// Serializes stereo PCM pairs into an I2S frame (LRCLK + SDATA), one slot per
// bit_strobe, with a one-entry holding buffer in front of the frame register.
//   WIDTH        param sample width per channel (16..31)
//   clk_in       in    system clock
//   rst_n        in    asynchronous active-low reset
//   bit_strobe   in    one-cycle pulse per bit-clock period
//   in_if        slave sample handshake (in_valid/in_ready/in_left/in_right)
//   lrclk        out   word select, 0 = left, 1 = right
//   sdata        out   serial data, MSB first, one-bit I2S delay
//   frame_start  out   high for the bit period of slot 0
//   underrun     out   high for the bit period of slot 0 when the frame muted
//   underrun_cnt out   saturating underrun count, only with I2S_TX_UNDERRUN_CNT_EN
// Optional feature macro: I2S_TX_UNDERRUN_CNT_EN.
// ---------------------------------------------------------------------------
module i2s_tx_serializer
  import i2s_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 bit_strobe,
  i2s_tx_serializer_if.slave   in_if,
  output logic                 lrclk,
  output logic                 sdata,
  output logic                 frame_start,
`ifdef I2S_TX_UNDERRUN_CNT_EN
  output logic [7:0]           underrun_cnt,
`endif
  output logic                 underrun
);

  logic         buf_valid_q, buf_valid_d;
  stereo_pair_t buf_q, buf_d;
  stereo_pair_t frame_q, frame_d;
  logic         sdata_q, sdata_d;
  logic         frame_start_q, frame_start_d;
  logic         underrun_q, underrun_d;

  logic         accept_s;
  logic [4:0]   pos_next_s;
  logic         chan_next_s;
  logic         frame_load_s;
  stereo_pair_t in_pair_s;

  i2s_slot_counter u_slot_counter (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .bit_strobe (bit_strobe),
    .lrclk      (lrclk),
    .pos_next   (pos_next_s),
    .chan_next  (chan_next_s),
    .frame_load (frame_load_s)
  );

  assign accept_s        = in_if.in_valid && !buf_valid_q;
  assign in_pair_s.left  = SLOT_BITS'(in_if.in_left);
  assign in_pair_s.right = SLOT_BITS'(in_if.in_right);

  // Next-state for buffer, frame register and the registered pin outputs
  always_comb begin
    buf_valid_d   = buf_valid_q;
    buf_d         = buf_q;
    frame_d       = frame_q;
    sdata_d       = sdata_q;
    frame_start_d = frame_start_q;
    underrun_d    = underrun_q;

    if (frame_load_s) begin
      frame_start_d = 1'b1;
      sdata_d       = 1'b0;                 // slot 0 is the delay bit
      if (buf_valid_q) begin
        frame_d     = buf_q;
        buf_valid_d = 1'b0;
        underrun_d  = 1'b0;
      end else begin
        // Mute this frame; a sample arriving now waits for the next one
        frame_d    = '0;
        underrun_d = 1'b1;
        if (accept_s) begin
          buf_d       = in_pair_s;
          buf_valid_d = 1'b1;
        end else begin
          buf_valid_d = 1'b0;
        end
      end
    end else begin
      if (accept_s) begin
        buf_d       = in_pair_s;
        buf_valid_d = 1'b1;
      end else begin
        buf_valid_d = buf_valid_q;
      end
      if (bit_strobe) begin
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;
        sdata_d = slot_bit(chan_next_s ? frame_q.right : frame_q.left,
                           pos_next_s, 6'(WIDTH));
      end else begin
        sdata_d = sdata_q;
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid_q   <= 1'b0;
      buf_q         <= '0;
      frame_q       <= '0;
      sdata_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      buf_valid_q   <= buf_valid_d;
      buf_q         <= buf_d;
      frame_q       <= frame_d;
      sdata_q       <= sdata_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [7:0] underrun_cnt_q, underrun_cnt_d;

  // Saturating count of muted frames
  always_comb begin
    underrun_cnt_d = underrun_cnt_q;
    if (frame_load_s && !buf_valid_q && (underrun_cnt_q != 8'd255)) begin
      underrun_cnt_d = underrun_cnt_q + 8'd1;
    end else begin
      underrun_cnt_d = underrun_cnt_q;
    end
  end

  // Underrun counter register
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      underrun_cnt_q <= 8'd0;
    end else begin
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign underrun_cnt = underrun_cnt_q;
`endif

  assign in_if.in_ready = !buf_valid_q;
  assign sdata          = sdata_q;
  assign frame_start    = frame_start_q;
  assign underrun       = underrun_q;

endmodule

// File: doc/i2s_tx_serializer.md
# i2s_tx_serializer

Downstream consumer of the divide-by-25 bit-clock generator: serializes stereo PCM samples into an I2S frame (LRCLK + SDATA), advancing exactly one bit per bit-clock strobe. Sits between the S/PDIF decoder's sample output and the I2S pins; BCLK itself comes from the clock divider, this block only drives LRCLK and SDATA in lockstep with it. A one-entry holding buffer with valid/ready decouples the decoder's sample timing from frame boundaries.

## Interface
- WIDTH, 24, sample width in bits per channel; legal range 16..31
- clk_in  in  1  system clock (same clock as the divider)
- rst_n  in  1  reset; asynchronous, active-low
- bit_strobe  in  1  one-cycle pulse per bit-clock period from the divider; all slot advances happen only on cycles where it is high
- in_valid  in  1  sample pair offered
- in_ready  out  1  holding buffer empty, sample accepted when in_valid && in_ready
- in_left  in  WIDTH  left sample, two's complement
- in_right  in  WIDTH  right sample, two's complement
- lrclk  out  1  word select; 0 = left, 1 = right
- sdata  out  1  serial data, MSB first
- frame_start  out  1  one-cycle pulse when slot 0 begins (frame register just loaded)
- underrun  out  1  one-cycle pulse when a frame starts with the holding buffer empty

## Operation
- Slot counter slot[5:0], 64 slots per frame; increments by 1 on each bit_strobe, wraps 63 -> 0.
- Channel = slot[5]; position pos = slot[4:0].
- lrclk = slot[5] (left for slots 0..31, right 32..63).
- sdata (standard I2S, one-bit delay): pos 1..WIDTH -> bit (WIDTH - pos) of current channel's frame sample; pos 0 and pos > WIDTH -> 0.
- Frame load on the strobe that moves slot 63 -> 0:
  - buffer full: frame registers <= buffer contents, buffer emptied, frame_start pulses.
  - buffer empty: frame registers <= 0 (mute), frame_start and underrun both pulse.
- Holding buffer: one entry; in_ready = buffer empty.
- Simultaneous accept and frame load with buffer empty: the frame mutes (no bypass), the incoming sample is stored in the buffer for the next frame.
- Simultaneous accept and frame load with buffer full: impossible (in_ready low).
- in_valid may be held while in_ready is low; in_left/in_right must stay stable until accepted.
- Reset, mid-frame or otherwise: slot = 63, lrclk = 1, sdata = 0, frame registers = 0, buffer empty, in_ready = 1, frame_start = 0, underrun = 0. The first strobe after reset starts a frame, which mutes and pulses underrun.

## Timing
- lrclk, sdata, frame_start and underrun are registered and update on the clk_in edge that samples bit_strobe high. They hold for the whole bit period.
- in_ready falls on the edge after acceptance. It rises on the edge of the frame load that consumes the buffer.
- Latency: the left MSB appears 1 strobe after the frame_start edge. The right MSB appears 33 strobes after it.
- Strobes arriving on consecutive clk_in cycles are legal. Each strobe advances one slot.

## Configuration
- I2S_TX_UNDERRUN_CNT_EN:
  - defined: adds output underrun_cnt [7:0]. It increments on each underrun pulse, saturates at 255 and resets to 0.
  - undefined: port absent. Only the underrun pulse exists.

## Structure
- Shared package i2s_pkg holds:
  - FRAME_SLOTS = 64 and SLOT_BITS = 32.
  - SLOT_W = 6.
  - A typedef for the stereo sample pair struct (left, right).
- Sub-module i2s_slot_counter holds the strobe-driven 6-bit wrap counter. It produces lrclk, pos and the frame-load pulse. The serializer datapath stays in the top.

## Test plan
- Reset release, strobe every 25 cycles, no input -> first strobe gives frame_start=1 and underrun=1; lrclk toggles every 32 strobes; sdata is 0 throughout.
- Accept left=0xA5A5A5, right=0x5A5A5A before a frame boundary -> after frame_start, left slots 1..24 carry 101001011010010110100101 and right slots 33..56 carry 010110100101101001011010; pos 0 and 25..31 are 0.
- Two back-to-back in_valid pairs within one frame -> first accepted and in_ready drops; second waits until the next frame load; both frames are serialized in order with no underrun.
- in_valid first asserted on the exact cycle of the 63 -> 0 strobe with the buffer empty -> that frame mutes with underrun=1; the sample plays in the following frame.
- rst_n asserted at slot 40 mid-frame -> outputs go to reset values immediately, independent of clk_in; the buffered sample is discarded; after release the first strobe starts slot 0.
- With I2S_TX_UNDERRUN_CNT_EN defined, run 300 empty frames -> underrun_cnt reads 255 and holds there.
